// File: rtl/exe_stage_md_if.sv
// exe_stage_md_if: decode->EX, EX->MS handshakes and the data SRAM request port.
// master is the EX stage side; slave is the surrounding pipeline/memory side.
interface exe_stage_md_if #(parameter int XLEN = 32);
    logic                  ds_to_es_valid;
    logic                  es_allowin;
    logic [4*XLEN+27:0]    ds_to_es_bus;
    logic                  es_to_ms_valid;
    logic                  ms_allowin;
    logic [2*XLEN+9:0]     es_to_ms_bus;
    logic                  data_sram_en;
    logic [XLEN/8-1:0]     data_sram_we;
    logic [XLEN-1:0]       data_sram_addr;
    logic [XLEN-1:0]       data_sram_wdata;
    modport master(
        input  ds_to_es_valid, ds_to_es_bus, ms_allowin,
        output es_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
    modport slave(
        output ds_to_es_valid, ds_to_es_bus, ms_allowin,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/exe_stage_md.sv
// exe_stage_md: execute stage with ALU, iterative restoring divider and data SRAM request.
// Divides stall the stage for XLEN+1 cycles; memory requests issue only on the EX->MS handshake.
module exe_stage_md #(
    parameter int XLEN   = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    exe_stage_md_if.master       io_es
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int SW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
    logic               r_es_valid;
    logic [4*XLEN+27:0] r_ds_bus;
    div_state_t         r_state;
    logic [SW-1:0]      r_cnt;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [11:0]        w_alu_op;
    logic [2:0]         w_div_op;
    logic [1:0]         w_mem_size;
    logic               w_load_op, w_store_op, w_src1_is_pc, w_src2_is_imm, w_src2_is_4, w_gr_we;
    logic [4:0]         w_dest;
    logic [XLEN-1:0]    w_imm, w_rj, w_rkd, w_pc;
    logic [XLEN-1:0]    w_src1, w_src2, w_alu_res, w_sra, w_result;
    logic signed [XLEN-1:0] w_s1s;
    logic [SW-1:0]      w_sh;
    logic               w_is_div, w_sgn, w_an, w_bn, w_dz, w_ready_go, w_hs, w_mem, w_ale;
    logic [XLEN-1:0]    w_aabs, w_babs, w_quo, w_rem;
    logic [XLEN:0]      w_trial;
    logic [7:0]         w_be8;
    assign {w_alu_op, w_div_op, w_mem_size, w_load_op, w_store_op, w_src1_is_pc, w_src2_is_imm,
            w_src2_is_4, w_gr_we, w_dest, w_imm, w_rj, w_rkd, w_pc} = r_ds_bus;
    assign w_src1 = w_src1_is_pc ? w_pc : w_rj;
    assign w_src2 = w_src2_is_imm ? w_imm : w_src2_is_4 ? XLEN'(4) : w_rkd;
    assign w_s1s  = w_src1;
    assign w_sh   = w_src2[SW-1:0];
    assign w_sra  = w_s1s >>> w_sh;
    always_comb begin
        w_alu_res = ({XLEN{w_alu_op[0]}}  & (w_src1 + w_src2))
                  | ({XLEN{w_alu_op[1]}}  & (w_src1 - w_src2))
                  | ({XLEN{w_alu_op[2]}}  & XLEN'($signed(w_src1) < $signed(w_src2)))
                  | ({XLEN{w_alu_op[3]}}  & XLEN'(w_src1 < w_src2))
                  | ({XLEN{w_alu_op[4]}}  & (w_src1 & w_src2))
                  | ({XLEN{w_alu_op[5]}}  & ~(w_src1 | w_src2))
                  | ({XLEN{w_alu_op[6]}}  & (w_src1 | w_src2))
                  | ({XLEN{w_alu_op[7]}}  & (w_src1 ^ w_src2))
                  | ({XLEN{w_alu_op[8]}}  & (w_src1 << w_sh))
                  | ({XLEN{w_alu_op[9]}}  & (w_src1 >> w_sh))
                  | ({XLEN{w_alu_op[10]}} & w_sra)
                  | ({XLEN{w_alu_op[11]}} & w_src2);
    end
    // Divider works on magnitudes; signs are reapplied once the quotient is complete.
    assign w_is_div = DIV_EN && w_div_op[2];
    assign w_sgn    = !w_div_op[1];
    assign w_an     = w_sgn && w_src1[XLEN-1];
    assign w_bn     = w_sgn && w_src2[XLEN-1];
    assign w_aabs   = w_an ? -w_src1 : w_src1;
    assign w_babs   = w_bn ? -w_src2 : w_src2;
    assign w_trial  = {r_rem, r_quo[XLEN-1]} - {1'b0, w_babs};
    assign w_dz     = w_src2 == '0;
    assign w_quo    = w_dz ? '1 : (w_an ^ w_bn) ? -r_quo : r_quo;
    assign w_rem    = w_dz ? w_src1 : w_an ? -r_rem : r_rem;
    assign w_result = w_is_div ? (w_div_op[0] ? w_rem : w_quo) : w_alu_res;
    assign w_ready_go           = !w_is_div || r_state == DONE;
    assign io_es.es_allowin     = !r_es_valid || (w_ready_go && io_es.ms_allowin);
    assign io_es.es_to_ms_valid = r_es_valid && w_ready_go && !flush;
    assign w_hs                 = io_es.es_to_ms_valid && io_es.ms_allowin;
    // Memory access: alignment mask grows with access size (byte/half/word/dword).
    assign w_mem = w_load_op || w_store_op;
    assign w_ale = w_mem && |(w_result[2:0] & {w_mem_size == 2'd3, w_mem_size[1], w_mem_size != 2'd0});
    assign w_be8 = w_mem_size == 2'd0 ? 8'h01 : w_mem_size == 2'd1 ? 8'h03 : w_mem_size == 2'd2 ? 8'h0F : 8'hFF;
    assign io_es.data_sram_en    = w_hs && w_mem && !w_ale;
    assign io_es.data_sram_we    = (io_es.data_sram_en && w_store_op) ? w_be8[NB-1:0] << w_result[OW-1:0] : '0;
    assign io_es.data_sram_addr  = w_result;
    assign io_es.data_sram_wdata = w_mem_size == 2'd0 ? {NB{w_rkd[7:0]}}
                                 : w_mem_size == 2'd1 ? {(XLEN/16){w_rkd[15:0]}}
                                 : w_mem_size == 2'd2 ? {(XLEN/32){w_rkd[31:0]}} : w_rkd;
    assign io_es.es_to_ms_bus    = {w_ale, w_mem_size, w_load_op, w_gr_we, w_dest, w_result, w_pc};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_es_valid <= 1'b0;
        else if (flush)
            r_es_valid <= 1'b0;
        else if (io_es.es_allowin)
            r_es_valid <= io_es.ds_to_es_valid;
    end
    always_ff @(posedge clk) begin
        if (io_es.es_allowin)
            r_ds_bus <= io_es.ds_to_es_bus;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: if (r_es_valid && w_is_div) begin
                    r_state <= BUSY;
                    r_cnt   <= '0;
                    r_rem   <= '0;
                    r_quo   <= w_aabs;
                end
                BUSY: begin
                    r_rem   <= w_trial[XLEN] ? {r_rem[XLEN-2:0], r_quo[XLEN-1]} : w_trial[XLEN-1:0];
                    r_quo   <= {r_quo[XLEN-2:0], !w_trial[XLEN]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == SW'(XLEN - 1))
                        r_state <= DONE;
                end
                DONE: if (w_hs)
                    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
